// File: rtl/max_score_tracker.sv
// max_score_tracker: reduces the per-PE score array to a single maximum
// through a two-stage comparator pipeline and folds it into a running best
// score and its matrix position for the traceback controller.
// Optional feature macro: MAX_TRACKER_POS_EN. When it is defined, the
// coordinate adders and coordinate pipeline are built. When it is undefined,
// max_row and max_col are tied to 0.
module max_score_tracker #(
  parameter int NUM_PU       = 4,
  parameter int NUM_ROWS_PE  = 2,
  parameter int NUM_COLS_PE  = 2,
  parameter int SCORE_WIDTH  = 10,
  parameter int SEQ_LENGTH_W = 5
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic [NUM_PU*NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH-1:0] scores_in,
  input  logic [NUM_PU-1:0]                                     valid_pu,
  input  logic [NUM_PU*SEQ_LENGTH_W-1:0]                        pu_row_base,
  input  logic [NUM_PU*SEQ_LENGTH_W-1:0]                        pu_col_base,
  input  logic                                                  last_wave,
  output logic [SCORE_WIDTH-1:0]                                max_score,
  output logic [SEQ_LENGTH_W-1:0]                               max_row,
  output logic [SEQ_LENGTH_W-1:0]                               max_col,
  output logic                                                  result_valid,
  output logic                                                  busy
);

  localparam int PE_PER_PU = NUM_ROWS_PE * NUM_COLS_PE;

  typedef enum logic [1:0] {IDLE, TRACK, DRAIN, DONE} state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_drainCnt;
  logic   w_accept;

  logic [SCORE_WIDTH-1:0]  w_s1Score [NUM_PU];
  logic [SCORE_WIDTH-1:0]  r_s1Score [NUM_PU];
  logic [NUM_PU-1:0]       r_s1Valid;

  logic                    w_s2Found;
  logic [SCORE_WIDTH-1:0]  w_s2Score;
  logic [SCORE_WIDTH-1:0]  r_s2Score;
  logic                    r_s2Valid;

  logic [SCORE_WIDTH-1:0]  r_maxScore;

`ifdef MAX_TRACKER_POS_EN
  logic [SEQ_LENGTH_W-1:0] w_s1Row [NUM_PU];
  logic [SEQ_LENGTH_W-1:0] w_s1Col [NUM_PU];
  logic [SEQ_LENGTH_W-1:0] r_s1Row [NUM_PU];
  logic [SEQ_LENGTH_W-1:0] r_s1Col [NUM_PU];
  logic [SEQ_LENGTH_W-1:0] w_s2Row;
  logic [SEQ_LENGTH_W-1:0] w_s2Col;
  logic [SEQ_LENGTH_W-1:0] r_s2Row;
  logic [SEQ_LENGTH_W-1:0] r_s2Col;
  logic [SEQ_LENGTH_W-1:0] r_maxRow;
  logic [SEQ_LENGTH_W-1:0] r_maxCol;
`else
  logic                    w_unusedBases;
  assign w_unusedBases = ^{pu_row_base, pu_col_base};
`endif

  // New data enters the pipeline only while tracking or in a start cycle.
  assign w_accept = start | (r_state == TRACK);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic; start overrides everything, including last_wave.
  always_comb begin
    w_nextState = r_state;
    if (start) begin
      w_nextState = TRACK;
    end else begin
      case (r_state)
        TRACK:   if (last_wave) w_nextState = DRAIN;
        DRAIN:   if (r_drainCnt) w_nextState = DONE;
        default: w_nextState = r_state;
      endcase
    end
  end

  // Drain counter: counts the two cycles needed to flush stages 1 and 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_drainCnt <= 1'b0;
    else if (start || r_state != DRAIN)    r_drainCnt <= 1'b0;
    else                                   r_drainCnt <= ~r_drainCnt;
  end

  // Stage 1 reduction: per-PU max in row-major order, first occurrence wins.
  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      w_s1Score[i] = scores_in[i*PE_PER_PU*SCORE_WIDTH +: SCORE_WIDTH];
`ifdef MAX_TRACKER_POS_EN
      w_s1Row[i] = pu_row_base[i*SEQ_LENGTH_W +: SEQ_LENGTH_W];
      w_s1Col[i] = pu_col_base[i*SEQ_LENGTH_W +: SEQ_LENGTH_W];
`endif
      for (int j = 0; j < NUM_ROWS_PE; j++) begin
        for (int k = 0; k < NUM_COLS_PE; k++) begin
          if (scores_in[((i*NUM_ROWS_PE + j)*NUM_COLS_PE + k)*SCORE_WIDTH +: SCORE_WIDTH]
              > w_s1Score[i]) begin
            w_s1Score[i] = scores_in[((i*NUM_ROWS_PE + j)*NUM_COLS_PE + k)*SCORE_WIDTH +: SCORE_WIDTH];
`ifdef MAX_TRACKER_POS_EN
            w_s1Row[i] = pu_row_base[i*SEQ_LENGTH_W +: SEQ_LENGTH_W] + SEQ_LENGTH_W'(j);
            w_s1Col[i] = pu_col_base[i*SEQ_LENGTH_W +: SEQ_LENGTH_W] + SEQ_LENGTH_W'(k);
`endif
          end
        end
      end
    end
  end

  // Stage 1 register; valids are masked when inputs are not being sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= '0;
      for (int i = 0; i < NUM_PU; i++) begin
        r_s1Score[i] <= '0;
`ifdef MAX_TRACKER_POS_EN
        r_s1Row[i]   <= '0;
        r_s1Col[i]   <= '0;
`endif
      end
    end else begin
      r_s1Valid <= valid_pu & {NUM_PU{w_accept}};
      for (int i = 0; i < NUM_PU; i++) begin
        r_s1Score[i] <= w_s1Score[i];
`ifdef MAX_TRACKER_POS_EN
        r_s1Row[i]   <= w_s1Row[i];
        r_s1Col[i]   <= w_s1Col[i];
`endif
      end
    end
  end

  // Stage 2 reduction across valid PUs; the lowest PU index wins ties.
  always_comb begin
    w_s2Found = 1'b0;
    w_s2Score = '0;
`ifdef MAX_TRACKER_POS_EN
    w_s2Row   = '0;
    w_s2Col   = '0;
`endif
    for (int i = 0; i < NUM_PU; i++) begin
      if (r_s1Valid[i] && (!w_s2Found || r_s1Score[i] > w_s2Score)) begin
        w_s2Found = 1'b1;
        w_s2Score = r_s1Score[i];
`ifdef MAX_TRACKER_POS_EN
        w_s2Row   = r_s1Row[i];
        w_s2Col   = r_s1Col[i];
`endif
      end
    end
  end

  // Stage 2 register; a start discards whatever belonged to the old alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_s2Score <= '0;
`ifdef MAX_TRACKER_POS_EN
      r_s2Row   <= '0;
      r_s2Col   <= '0;
`endif
    end else begin
      r_s2Valid <= w_s2Found & ~start;
      r_s2Score <= w_s2Score;
`ifdef MAX_TRACKER_POS_EN
      r_s2Row   <= w_s2Row;
      r_s2Col   <= w_s2Col;
`endif
    end
  end

  // Stage 3 running maximum; strict compare keeps the earliest occurrence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_maxScore <= '0;
`ifdef MAX_TRACKER_POS_EN
      r_maxRow   <= '0;
      r_maxCol   <= '0;
`endif
    end else if (start) begin
      r_maxScore <= '0;
`ifdef MAX_TRACKER_POS_EN
      r_maxRow   <= '0;
      r_maxCol   <= '0;
`endif
    end else if (r_s2Valid && r_s2Score > r_maxScore) begin
      r_maxScore <= r_s2Score;
`ifdef MAX_TRACKER_POS_EN
      r_maxRow   <= r_s2Row;
      r_maxCol   <= r_s2Col;
`endif
    end
  end

  assign max_score    = r_maxScore;
`ifdef MAX_TRACKER_POS_EN
  assign max_row      = r_maxRow;
  assign max_col      = r_maxCol;
`else
  assign max_row      = '0;
  assign max_col      = '0;
`endif
  assign result_valid = (r_state == DONE);
  assign busy         = (r_state == TRACK) || (r_state == DRAIN);

endmodule

// File: doc/max_score_tracker.md
# max_score_tracker

Downstream consumer of the matrix-calculation stage's registered per-PE score array. Every cycle it reduces all valid PE scores to a single maximum through a two-stage comparator pipeline. It folds that maximum into a running maximum, together with the matrix cell coordinates. When the controller signals the last wavefront, it drains the pipeline and presents the alignment's best score and end position to the traceback controller.

## Interface
- NUM_PU, 4: number of processing units feeding scores.
- NUM_ROWS_PE, 2: PE rows per PU.
- NUM_COLS_PE, 2: PE columns per PU.
- SCORE_WIDTH, 10: unsigned score width.
- SEQ_LENGTH_W, 5: coordinate width; matrix index is in 0..2^SEQ_LENGTH_W-1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears tracker and begins a new alignment.
- scores_in  in  NUM_PU×NUM_ROWS_PE×NUM_COLS_PE×SCORE_WIDTH  registered PE scores from the calculation stage.
- valid_pu  in  NUM_PU  per-PU valid; this is the calculation stage's write enable delayed one cycle, aligned with scores_in.
- pu_row_base  in  NUM_PU×SEQ_LENGTH_W  matrix row of PE[0][*] for each PU, aligned with scores_in; always even.
- pu_col_base  in  NUM_PU×SEQ_LENGTH_W  matrix column of PE[*][0] for each PU; always even.
- last_wave  in  1  high in the cycle carrying the final valid scores.
- max_score  out  SCORE_WIDTH  running or final maximum.
- max_row  out  SEQ_LENGTH_W  row of max_score.
- max_col  out  SEQ_LENGTH_W  column of max_score.
- result_valid  out  1  final result stable.
- busy  out  1  high in TRACK and DRAIN.

## Operation
- FSM states are IDLE, TRACK, DRAIN, DONE.
- IDLE → TRACK on start.
- TRACK → DRAIN on last_wave.
- DRAIN → DONE after 2 cycles, when the pipeline is empty.
- DONE → TRACK on start.
- start in any state, including TRACK and DRAIN, clears the running max, position, pipeline valids and drain counter, then enters TRACK. Data presented in the start cycle is accepted.
- Inputs are sampled only in TRACK and in the start cycle; valid_pu and last_wave are ignored otherwise.
- Cell coordinates are row = pu_row_base[i] + j and col = pu_col_base[i] + k, computed modulo 2^SEQ_LENGTH_W.
- Stage 1 (per PU): maximum of NUM_ROWS_PE×NUM_COLS_PE PE scores plus coordinate; result registered with a valid bit equal to valid_pu[i].
- Stage 2: maximum across valid PUs, registered; stage valid is the OR of the PU valids. Invalid PUs never win.
- Stage 3: if stage-2 valid and stage-2 score > running max (strictly greater), load score, row and col.
- Tie-break within a cycle: lowest PU index wins, then row-major PE order with [0][0] first.
- Tie-break across cycles: the earliest occurrence is kept.
- Scores are unsigned and compared at full SCORE_WIDTH with no saturation.
- If every score is 0 or nothing is valid, the result is max_score 0 at (0,0).

## Timing
- Reset values: max_score, max_row, max_col and result_valid are 0; busy is 0; FSM is IDLE; pipeline valids are 0.
- Scores valid in cycle t are visible on max_* from cycle t+3, i.e. after the third rising edge.
- max_* show the running value throughout TRACK; consumers use them only when result_valid is high.
- last_wave in cycle t: DRAIN during t+1 and t+2; result_valid is high and busy low from t+3.
- result_valid holds in DONE until start or rst; it drops the cycle after start.
- start and last_wave in the same cycle: start wins, the state is TRACK, and last_wave is ignored.
- rst mid-operation immediately forces reset values, independent of the clock.

## Configuration
- MAX_TRACKER_POS_EN defined: coordinate adders and the coordinate pipeline are present, and max_row/max_col are tracked as above.
- MAX_TRACKER_POS_EN undefined: the coordinate logic is removed, and max_row/max_col are constant 0.
- Score tracking, FSM and timing are identical in both builds.

## Test plan
- Reset, then start; one cycle with valid_pu=4'b0001, PU0 scores {3,9,4,1}, bases (2,6), last_wave=1 → result_valid at t+3 with max_score 9, row 2, col 7.
- Two PUs both holding 15 in the same cycle, PU1 and PU3 → PU1's coordinates are reported.
- Score 20 in cycle 1, then 20 at a different cell in cycle 5 → the cycle-1 position is retained.
- Score 31 on PU2 with valid_pu[2]=0, other valid max 5 → max_score 5.
- start asserted while in DRAIN after a max of 40 has been accumulated → busy stays high, result_valid stays 0, next max is rebuilt from 0.
- rst pulsed while in DONE showing 12 → all outputs 0 asynchronously. With MAX_TRACKER_POS_EN undefined, rerun the first scenario → max_score 9, row 0, col 0.
